// File: rtl/nts_tx_dispatch_arbiter_pkg.sv
// rtl/nts_tx_dispatch_arbiter_pkg.sv - shared state encoding and MAC byte-mask helpers
package nts_tx_dispatch_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_READ      = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_SEND      = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  localparam logic [7:0] MAC_MASK_ALL = 8'hFF;

  function automatic logic bytes_illegal(input logic [3:0] bytes);
    return (bytes == 4'd0) || (bytes > 4'd8);
  endfunction

  // Byte 0 sits in the MSBs, so a short last word keeps the upper mask bits.
  function automatic logic [7:0] last_word_mask(input logic [3:0] bytes);
    if (bytes_illegal(bytes)) return MAC_MASK_ALL;
    return MAC_MASK_ALL << (4'd8 - bytes);
  endfunction

endpackage

// File: rtl/nts_rr_arbiter.sv
// rtl/nts_rr_arbiter.sv - combinational round-robin picker
// Searches upward from last_grant+1 (mod N); the nearest requester wins.
module nts_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  int           idx;
  logic [W-1:0] sel;

  // Walk from farthest to nearest so the last hit is the closest requester.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % N;
      sel = W'(idx);
      if (req[sel]) begin
        grant       = sel;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nts_tx_dispatch_arbiter.sv
// rtl/nts_tx_dispatch_arbiter.sv - shares one MAC Tx port among NTS engine Tx buffers
// Picks an engine round-robin, drains its FIFO onto the MAC stream, then releases the buffer.
module nts_tx_dispatch_arbiter
  import nts_tx_dispatch_arbiter_pkg::*;
#(
  parameter int ENGINES  = 4,
  parameter int ENGINE_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [ENGINES-1:0]    i_engine_packet_available,
  output logic [ENGINES-1:0]    o_engine_packet_read,
  input  logic [ENGINES-1:0]    i_engine_fifo_empty,
  output logic [ENGINES-1:0]    o_engine_fifo_rd_en,
  input  logic [64*ENGINES-1:0] i_engine_fifo_rd_data,
  input  logic [4*ENGINES-1:0]  i_engine_bytes_last_word,
  output logic [63:0]           o_mac_data,
  output logic [7:0]            o_mac_data_valid,
  output logic                  o_mac_last,
  input  logic                  i_mac_ready,
  output logic [ENGINE_W-1:0]   o_grant,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [31:0]           o_packets_sent
);

  state_t               state;
  logic [ENGINE_W-1:0]  last_grant;
  logic [ENGINE_W-1:0]  pick;
  logic                 pick_valid;
  logic                 word_sent;
  logic [63:0]          sel_data;
  logic [3:0]           sel_bytes;
  logic                 sel_empty;
  logic [ENGINES-1:0]   grant_onehot;

  nts_rr_arbiter #(
    .N (ENGINES),
    .W (ENGINE_W)
  ) u_rr (
    .req         (i_engine_packet_available),
    .last_grant  (last_grant),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  assign grant_onehot = ENGINES'(1) << o_grant;

  always_comb begin
    sel_data  = '0;
    sel_bytes = '0;
    sel_empty = 1'b1;
    for (int e = 0; e < ENGINES; e++) begin
      if (o_grant == ENGINE_W'(e)) begin
        sel_data  = i_engine_fifo_rd_data[64*e +: 64];
        sel_bytes = i_engine_bytes_last_word[4*e +: 4];
        sel_empty = i_engine_fifo_empty[e];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state                <= ST_IDLE;
      last_grant           <= ENGINE_W'(ENGINES - 1);
      word_sent            <= 1'b0;
      o_engine_packet_read <= '0;
      o_engine_fifo_rd_en  <= '0;
      o_mac_data           <= '0;
      o_mac_data_valid     <= '0;
      o_mac_last           <= 1'b0;
      o_grant              <= '0;
      o_busy               <= 1'b0;
      o_error              <= 1'b0;
      o_packets_sent       <= '0;
    end else begin
      o_engine_packet_read <= '0;
      o_engine_fifo_rd_en  <= '0;
      o_error              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            o_grant   <= pick;
            word_sent <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (sel_empty) begin
            o_engine_packet_read <= grant_onehot;
            state                <= ST_RELEASE;
          end else begin
            o_engine_fifo_rd_en <= grant_onehot;
            state               <= ST_READ;
          end
        end
        ST_READ: state <= ST_WAIT_DATA;
        // FIFO empty right after the pop means this word closes the packet.
        ST_WAIT_DATA: begin
          o_mac_data       <= sel_data;
          o_mac_last       <= sel_empty;
          o_mac_data_valid <= sel_empty ? last_word_mask(sel_bytes) : MAC_MASK_ALL;
          o_error          <= sel_empty && bytes_illegal(sel_bytes);
          state            <= ST_SEND;
        end
        ST_SEND: begin
          if (i_mac_ready) begin
            o_mac_data       <= '0;
            o_mac_data_valid <= '0;
            o_mac_last       <= 1'b0;
            word_sent        <= 1'b1;
            if (o_mac_last) begin
              o_engine_packet_read <= grant_onehot;
              state                <= ST_RELEASE;
            end else begin
              o_engine_fifo_rd_en <= grant_onehot;
              state               <= ST_READ;
            end
          end
        end
        ST_RELEASE: begin
          last_grant <= o_grant;
          if (word_sent) o_packets_sent <= o_packets_sent + 32'd1;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_tx_dispatch_arbiter.sv
// tb/tb_nts_tx_dispatch_arbiter.sv - directed self-checking bench for nts_tx_dispatch_arbiter
module tb_nts_tx_dispatch_arbiter;

  localparam int ENG = 4;

  logic            i_clk;
  logic            i_areset;
  logic [ENG-1:0]  i_engine_packet_available;
  logic [ENG-1:0]  o_engine_packet_read;
  logic [ENG-1:0]  i_engine_fifo_empty;
  logic [ENG-1:0]  o_engine_fifo_rd_en;
  logic [64*ENG-1:0] i_engine_fifo_rd_data;
  logic [4*ENG-1:0]  i_engine_bytes_last_word;
  logic [63:0]     o_mac_data;
  logic [7:0]      o_mac_data_valid;
  logic            o_mac_last;
  logic            i_mac_ready;
  logic [1:0]      o_grant;
  logic            o_busy;
  logic            o_error;
  logic [31:0]     o_packets_sent;

  nts_tx_dispatch_arbiter #(.ENGINES(ENG), .ENGINE_W(2)) dut (
    .i_clk                     (i_clk),
    .i_areset                  (i_areset),
    .i_engine_packet_available (i_engine_packet_available),
    .o_engine_packet_read      (o_engine_packet_read),
    .i_engine_fifo_empty       (i_engine_fifo_empty),
    .o_engine_fifo_rd_en       (o_engine_fifo_rd_en),
    .i_engine_fifo_rd_data     (i_engine_fifo_rd_data),
    .i_engine_bytes_last_word  (i_engine_bytes_last_word),
    .o_mac_data                (o_mac_data),
    .o_mac_data_valid          (o_mac_data_valid),
    .o_mac_last                (o_mac_last),
    .i_mac_ready               (i_mac_ready),
    .o_grant                   (o_grant),
    .o_busy                    (o_busy),
    .o_error                   (o_error),
    .o_packets_sent            (o_packets_sent)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] fifo_q [ENG][$];
  logic [63:0] cap_data[$];
  logic [7:0]  cap_mask[$];
  logic        cap_last[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_mask[$];
  logic        exp_last[$];
  int          order_q[$];
  int          rel_cnt [ENG];
  int          rd_en_cnt = 0;
  int          err_cnt = 0;
  int          onehot_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dword(input int e, input int p, input int i);
    return {8'(e), 8'(p), 16'hC0DE, 32'(i)};
  endfunction

  // Engine FIFO model: data appears the cycle after rd_en; buffer drops availability on release.
  initial begin
    for (int e = 0; e < ENG; e++) rel_cnt[e] = 0;
    forever begin
      @(negedge i_clk);
      if (!i_areset) begin
        for (int e = 0; e < ENG; e++) begin
          if (o_engine_fifo_rd_en[e]) begin
            rd_en_cnt++;
            if (fifo_q[e].size() > 0) i_engine_fifo_rd_data[64*e +: 64] = fifo_q[e].pop_front();
            i_engine_fifo_empty[e] = (fifo_q[e].size() == 0);
          end
          if (o_engine_packet_read[e]) begin
            i_engine_packet_available[e] = 1'b0;
            rel_cnt[e]++;
            order_q.push_back(e);
          end
        end
        if ($countones(o_engine_fifo_rd_en) > 1 || $countones(o_engine_packet_read) > 1) onehot_bad++;
        if (o_error) err_cnt++;
        if (o_mac_data_valid != 8'h00 && i_mac_ready) begin
          cap_data.push_back(o_mac_data);
          cap_mask.push_back(o_mac_data_valid);
          cap_last.push_back(o_mac_last);
        end
      end
    end
  end

  task automatic load(input int e, input int p, input int n, input int b);
    for (int i = 0; i < n; i++) fifo_q[e].push_back(dword(e, p, i));
    i_engine_bytes_last_word[4*e +: 4] = 4'(b);
    i_engine_fifo_empty[e] = (n == 0);
    i_engine_packet_available[e] = 1'b1;
  endtask

  task automatic expect_pkt(input int e, input int p, input int n, input logic [7:0] last_mask);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(dword(e, p, i));
      exp_mask.push_back(i == n - 1 ? last_mask : 8'hFF);
      exp_last.push_back(i == n - 1);
    end
  endtask

  task automatic verify_words(input string tag);
    check({tag, "_count"}, 64'(cap_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
      check($sformatf("%s_mask%0d", tag, i), 64'(cap_mask[i]), 64'(exp_mask[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(cap_last[i]), 64'(exp_last[i]));
    end
    cap_data.delete(); cap_mask.delete(); cap_last.delete();
    exp_data.delete(); exp_mask.delete(); exp_last.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(posedge i_clk); #1;
      if (i_engine_packet_available == '0 && !o_busy) done = 1'b1;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] hold_d;
    logic [7:0]  hold_m;
    logic        hold_l;
    bit          stable;
    bit          seen;
    int          lat;
    int          snap_rd;
    int          snap_rel;
    int          snap_err;

    i_areset = 1'b1;
    i_engine_packet_available = '0;
    i_engine_fifo_empty = '1;
    i_engine_fifo_rd_data = '0;
    i_engine_bytes_last_word = '0;
    i_mac_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", 64'(o_mac_data_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_sent", 64'(o_packets_sent), 64'd0);
    check("rst_rd_en", 64'(o_engine_fifo_rd_en), 64'd0);
    check("rst_pkt_read", 64'(o_engine_packet_read), 64'd0);
    check("rst_grant", 64'(o_grant), 64'd0);
    i_areset = 1'b0;

    // Fresh reset favours engine 0, then walks upward.
    @(posedge i_clk); #1;
    load(0, 8'h10, 1, 8); load(1, 8'h11, 1, 8); load(2, 8'h12, 1, 8);
    expect_pkt(0, 8'h10, 1, 8'hFF); expect_pkt(1, 8'h11, 1, 8'hFF); expect_pkt(2, 8'h12, 1, 8'hFF);
    wait_idle("rr3");
    check("rr3_order_n", 64'(order_q.size()), 64'd3);
    if (order_q.size() == 3) begin
      check("rr3_first", 64'(order_q[0]), 64'd0);
      check("rr3_second", 64'(order_q[1]), 64'd1);
      check("rr3_third", 64'(order_q[2]), 64'd2);
    end
    verify_words("rr3");
    check("rr3_sent", 64'(o_packets_sent), 64'd3);
    order_q.delete();

    // last_grant is 2: engine 3 is nearer than engine 0.
    load(0, 8'h20, 1, 8); load(3, 8'h23, 1, 3);
    expect_pkt(3, 8'h23, 1, 8'hE0); expect_pkt(0, 8'h20, 1, 8'hFF);
    wait_idle("rr2");
    check("rr2_order_n", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      check("rr2_first", 64'(order_q[0]), 64'd3);
      check("rr2_second", 64'(order_q[1]), 64'd0);
    end
    verify_words("rr2");
    check("rr2_sent", 64'(o_packets_sent), 64'd5);
    order_q.delete();

    // Single 3-word packet, 5 bytes in the last word; first word 4 cycles after request.
    snap_rel = rel_cnt[0];
    load(0, 8'h30, 3, 5);
    expect_pkt(0, 8'h30, 3, 8'hF8);
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_mac_data_valid != 8'h00) seen = 1'b1;
    end
    check("single_latency", 64'(lat), 64'd4);
    wait_idle("single");
    verify_words("single");
    check("single_release", 64'(rel_cnt[0] - snap_rel), 64'd1);
    check("single_sent", 64'(o_packets_sent), 64'd6);

    // Backpressure on word 2 of engine 1.
    snap_rd = rd_en_cnt;
    load(1, 8'h40, 3, 8);
    expect_pkt(1, 8'h40, 3, 8'hFF);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (o_mac_data_valid != 8'h00 && cap_data.size() == 1) seen = 1'b1;
    end
    check("bp_reach_word2", 64'(seen), 64'd1);
    hold_d = o_mac_data; hold_m = o_mac_data_valid; hold_l = o_mac_last;
    i_mac_ready = 1'b0;
    stable = 1'b1;
    repeat (10) begin
      @(posedge i_clk); #1;
      if (o_mac_data !== hold_d || o_mac_data_valid !== hold_m || o_mac_last !== hold_l) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_held_word", hold_d, dword(1, 8'h40, 1));
    check("bp_no_extra_rd", 64'(rd_en_cnt - snap_rd), 64'd2);
    check("bp_no_accept", 64'(cap_data.size()), 64'd1);
    i_mac_ready = 1'b1;
    wait_idle("bp");
    verify_words("bp");
    check("bp_total_rd", 64'(rd_en_cnt - snap_rd), 64'd3);
    check("bp_sent", 64'(o_packets_sent), 64'd7);

    // Empty packet: released without touching the MAC or the counter.
    snap_rel = rel_cnt[3];
    snap_rd = rd_en_cnt;
    load(3, 8'h50, 0, 8);
    wait_idle("empty");
    check("empty_no_words", 64'(cap_data.size()), 64'd0);
    check("empty_release", 64'(rel_cnt[3] - snap_rel), 64'd1);
    check("empty_no_rd", 64'(rd_en_cnt - snap_rd), 64'd0);
    check("empty_sent", 64'(o_packets_sent), 64'd7);

    // Illegal byte count on the last word.
    snap_err = err_cnt;
    load(2, 8'h60, 2, 0);
    expect_pkt(2, 8'h60, 2, 8'hFF);
    wait_idle("b0");
    verify_words("b0");
    check("b0_error_pulses", 64'(err_cnt - snap_err), 64'd1);
    check("b0_sent", 64'(o_packets_sent), 64'd8);
    check("onehot", 64'(onehot_bad), 64'd0);

    // Reset in the middle of SEND drops everything immediately.
    snap_rel = rel_cnt[0];
    i_mac_ready = 1'b0;
    load(0, 8'h70, 2, 8);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (o_mac_data_valid != 8'h00) seen = 1'b1;
    end
    check("mid_reach_send", 64'(seen), 64'd1);
    i_areset = 1'b1;
    #1;
    check("mid_valid", 64'(o_mac_data_valid), 64'd0);
    check("mid_data", o_mac_data, 64'd0);
    check("mid_last", 64'(o_mac_last), 64'd0);
    check("mid_busy", 64'(o_busy), 64'd0);
    check("mid_sent", 64'(o_packets_sent), 64'd0);
    check("mid_rd_en", 64'(o_engine_fifo_rd_en), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    check("mid_no_release", 64'(rel_cnt[0] - snap_rel), 64'd0);
    check("mid_pkt_read", 64'(o_engine_packet_read), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
